// File: rtl/dataflow_pkg.sv
// Shared types and constants for the lane dataflow return path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dataflow_pkg;

    localparam int IL_DEF = 4;
    localparam int FL_DEF = 16;
    localparam int W_DEF  = IL_DEF + FL_DEF;

    // Signed fixed-point word at the default IL.FL format.
    typedef logic signed [W_DEF-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        REDUCE = 2'd2,
        EMIT   = 2'd3
    } collect_state_t;

    // Saturation bounds at the default word width.
    localparam fixed_t SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam fixed_t SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

endpackage

// File: rtl/dataflow_collect_sat_add_vec.sv
// 16-wide signed saturating adder (sum clamps to the W-bit signed range).
// Latency: combinational.
// Backpressure: none (pure function of a and b).
// Ports: a, b = 16 addend words; sum = 16 saturated results.
module sat_add_vec
    import dataflow_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic signed [W-1:0] a   [16],
    input  logic signed [W-1:0] b   [16],
    output logic signed [W-1:0] sum [16]
);

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide [16];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            // One guard bit is enough for a two-operand add; overflow shows
            // as the guard bit disagreeing with the result's sign bit.
            wide[k] = {a[k][W-1], a[k]} + {b[k][W-1], b[k]};
            if (wide[k][W] != wide[k][W-1]) begin
                sum[k] = wide[k][W] ? MIN_V : MAX_V;
            end else begin
                sum[k] = wide[k][W-1:0];
            end
        end
    end

endmodule

// File: rtl/dataflow_collect.sv
// Captures the lane x 16 result array and returns it as per-lane beats (mode 1) or one saturated lane-sum beat (mode 0).
// Latency: drain first beat 1 cycle after capture; reduce beat after lane cycles (1 when lane==1).
// Backpressure: out_ready low holds the current beat stable; in_ready is high only in IDLE, so new blocks wait.
// Ports: clk/reset (async active-low); mode, in_valid/in_ready, in[lane][16] on the capture side;
//        out_valid/out_ready, out[16], out_lane, out_last on the beat side.
module dataflow_collect
    import dataflow_pkg::*;
#(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int lane = 128,
    localparam int W   = IL + FL,
    localparam int CW  = (lane > 1) ? $clog2(lane) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  in [lane][16],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  out [16],
    output logic [CW-1:0]        out_lane,
    output logic                 out_last
);

    localparam logic [CW-1:0] LAST_LANE = CW'(lane - 1);

    collect_state_t     state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic signed [W-1:0] reg_in_q [lane][16];
    logic signed [W-1:0] reg_in_d [lane][16];
    logic signed [W-1:0] acc_q    [16];
    logic signed [W-1:0] acc_d    [16];

    // Lane currently addressed by the counter: the drain beat, or the
    // addend for the next reduction step.
    logic signed [W-1:0] lane_sel [16];
    logic signed [W-1:0] acc_sum  [16];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            lane_sel[k] = reg_in_q[cnt_q][k];
        end
    end

    sat_add_vec #(.W(W)) u_sat_add (
        .a   (acc_q),
        .b   (lane_sel),
        .sum (acc_sum)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        reg_in_d = reg_in_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    reg_in_d = in;
                    mode_d   = mode;
                    if (mode) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        // Lane 0 seeds the accumulator directly from the
                        // input so REDUCE only needs lane-1 add steps.
                        for (int k = 0; k < 16; k++) begin
                            acc_d[k] = in[0][k];
                        end
                        cnt_d   = CW'(1);
                        state_d = (lane == 1) ? EMIT : REDUCE;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == LAST_LANE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            REDUCE: begin
                acc_d = acc_sum;
                if (cnt_q == LAST_LANE) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            for (int j = 0; j < lane; j++) begin
                for (int k = 0; k < 16; k++) begin
                    reg_in_q[j][k] <= '0;
                end
            end
            for (int k = 0; k < 16; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            reg_in_q <= reg_in_d;
            acc_q    <= acc_d;
        end
    end

    // Outputs depend only on registered state, so a stalled beat cannot
    // move until the state or counter advances on a handshake.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DRAIN) || (state_q == EMIT);
    assign out_last  = (state_q == EMIT) || ((state_q == DRAIN) && (cnt_q == LAST_LANE));
    assign out_lane  = (state_q == DRAIN) ? cnt_q : '0;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            out[k] = '0;
            if (out_valid) begin
                out[k] = mode_q ? lane_sel[k] : acc_q[k];
            end
        end
    end

endmodule

// File: tb/tb_dataflow_collect.sv
module tb_dataflow_collect;

    localparam int L    = 4;
    localparam int W    = 20;
    localparam int MAXV = 524287;
    localparam int MINV = -524288;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                mode = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_arr [L][16];
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] out_arr [16];
    logic [1:0]          out_lane;
    logic                out_last;

    int checks = 0;
    int errors = 0;

    int blk [L][16];
    int exp_w[$];
    int exp_ln[$];
    int exp_last[$];
    int cyc;
    int last_w0;
    int last_w15;

    always #5 clk = ~clk;

    dataflow_collect #(.IL(4), .FL(16), .lane(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_arr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_arr),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Reference: drain emits each lane as-is; reduce folds lanes in order
    // with a clamp after every addition.
    task automatic build_expect(input bit m);
        int acc [16];
        if (m) begin
            for (int j = 0; j < L; j++) begin
                for (int k = 0; k < 16; k++) exp_w.push_back(blk[j][k]);
                exp_ln.push_back(j);
                exp_last.push_back(j == L - 1);
            end
        end else begin
            for (int k = 0; k < 16; k++) begin
                acc[k] = blk[0][k];
                for (int j = 1; j < L; j++) acc[k] = sat(acc[k] + blk[j][k]);
                exp_w.push_back(acc[k]);
            end
            exp_ln.push_back(0);
            exp_last.push_back(1);
        end
    endtask

    task automatic send(input bit m, input bit junk);
        int budget = 50;
        build_expect(m);
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("in_ready_before_capture", in_ready, 1);
        for (int j = 0; j < L; j++)
            for (int k = 0; k < 16; k++) in_arr[j][k] = W'(blk[j][k]);
        mode = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Flip mode and optionally keep offering junk to prove neither
        // affects the block in flight.
        mode = ~m;
        in_valid = junk;
        if (junk) begin
            for (int j = 0; j < L; j++)
                for (int k = 0; k < 16; k++) in_arr[j][k] = W'($urandom);
        end
    endtask

    task automatic collect(input int stall_beat, input bit rnd, output int ncyc);
        int budget = 300;
        int beat = 0;
        int stall_left = 3;
        bit have_prev = 1'b0;
        logic [1:0] prev_ln;
        logic signed [W-1:0] prev_w0;
        logic signed [W-1:0] prev_w15;
        logic prev_last;
        int e;
        ncyc = 0;
        while (exp_ln.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            ncyc++;
            if (have_prev) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_lane", out_lane, prev_ln);
                chk("stall_hold_last", out_last, prev_last);
                chk("stall_hold_w0", out_arr[0], prev_w0);
                chk("stall_hold_w15", out_arr[15], prev_w15);
                have_prev = 1'b0;
            end
            if (beat == stall_beat && stall_left > 0 && out_valid) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (rnd) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                for (int k = 0; k < 16; k++) begin
                    e = exp_w.pop_front();
                    chk($sformatf("beat%0d_w%0d", beat, k), out_arr[k], e);
                end
                chk($sformatf("beat%0d_lane", beat), out_lane, exp_ln.pop_front());
                chk($sformatf("beat%0d_last", beat), out_last, exp_last.pop_front());
                last_w0  = int'(out_arr[0]);
                last_w15 = int'(out_arr[15]);
                beat++;
                if (exp_ln.size() == 0) in_valid = 1'b0;
            end else if (out_valid) begin
                have_prev = 1'b1;
                prev_ln   = out_lane;
                prev_last = out_last;
                prev_w0   = out_arr[0];
                prev_w15  = out_arr[15];
            end
        end
        chk("beats_outstanding", exp_ln.size(), 0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("after_block_in_ready", in_ready, 1);
        chk("after_block_out_valid", out_valid, 0);
    endtask

    initial begin
        for (int j = 0; j < L; j++)
            for (int k = 0; k < 16; k++) in_arr[j][k] = '0;

        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        chk("in_reset_out_valid", out_valid, 0);
        chk("in_reset_in_ready", in_ready, 1);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_in_ready", in_ready, 1);
            chk("idle_out_lane", out_lane, 0);
            chk("idle_out_last", out_last, 0);
            chk("idle_out_w0", out_arr[0], 0);
            chk("idle_out_w15", out_arr[15], 0);
        end

        // Drain, no backpressure: beats on consecutive cycles.
        for (int j = 0; j < L; j++)
            for (int k = 0; k < 16; k++) blk[j][k] = j * 'h10000 + k;
        send(1'b1, 1'b0);
        collect(-1, 1'b0, cyc);
        chk("drain_cycles", cyc, 4);

        // Drain with three stall cycles on beat 1.
        send(1'b1, 1'b0);
        collect(1, 1'b0, cyc);
        chk("drain_stall_cycles", cyc, 7);

        // Reduce: 1.0 - 0.5 + 0.25 + 0 = 0.75.
        for (int k = 0; k < 16; k++) begin
            blk[0][k] = 'h10000;
            blk[1][k] = -'h8000;
            blk[2][k] = 'h4000;
            blk[3][k] = 0;
        end
        send(1'b0, 1'b0);
        collect(-1, 1'b0, cyc);
        chk("reduce_latency", cyc, 4);
        chk("reduce_value", last_w0, 32'h0000C000);

        // Positive and negative saturation.
        for (int j = 0; j < L; j++)
            for (int k = 0; k < 16; k++) blk[j][k] = 'h28000;
        send(1'b0, 1'b0);
        collect(-1, 1'b0, cyc);
        chk("sat_max", last_w15, 32'h0007FFFF);
        for (int j = 0; j < L; j++)
            for (int k = 0; k < 16; k++) blk[j][k] = -'h28000;
        send(1'b0, 1'b0);
        collect(-1, 1'b0, cyc);
        chk("sat_min", last_w15, 32'hFFF80000);

        // Reset in the middle of a drain, after beat 1 is accepted.
        for (int j = 0; j < L; j++)
            for (int k = 0; k < 16; k++) blk[j][k] = 'h100 + j * 'h1000 + k;
        send(1'b1, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        chk("rst_pre_beat0_lane", out_lane, 0);
        @(negedge clk);
        chk("rst_pre_beat1_lane", out_lane, 1);
        chk("rst_pre_beat1_valid", out_valid, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_in_ready", in_ready, 1);
        chk("rst_async_out_lane", out_lane, 0);
        chk("rst_async_w0", out_arr[0], 0);
        exp_w.delete();
        exp_ln.delete();
        exp_last.delete();
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_release_out_valid", out_valid, 0);
        for (int j = 0; j < L; j++)
            for (int k = 0; k < 16; k++) blk[j][k] = -'h300 - j * 'h2000 - k;
        send(1'b1, 1'b0);
        collect(-1, 1'b0, cyc);
        chk("rst_new_block_cycles", cyc, 4);

        // Randomized blocks: random mode, data, backpressure and junk input.
        for (int b = 0; b < 16; b++) begin
            for (int j = 0; j < L; j++)
                for (int k = 0; k < 16; k++) begin
                    if (b % 2 == 0) blk[j][k] = int'($signed(20'($urandom)));
                    else blk[j][k] = int'($urandom_range(0, 'h3FFFF)) - 'h20000;
                end
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            collect(-1, 1'b1, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dataflow_collect.md
Name: dataflow_collect

Overview:
- Return-path counterpart of the lane dataflow stage. It captures the lane x 16 result array produced by the compute lanes and hands it back to the buffer side through a valid/ready stream.
- Mode 1 (per-lane): drains one lane (16 words) per beat.
- Mode 0 (reduce): sums all lanes element-wise with saturation and emits a single 16-word beat.
- Sits between the lane array outputs and the activation/buffer write port.

Parameters:
IL, 4, integer bits of the signed fixed-point word
FL, 16, fractional bits of the signed fixed-point word
lane, 128, number of lanes (>=1); lane counter width is max(1, clog2(lane))

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
mode  in  1  0 = reduce across lanes, 1 = per-lane drain; sampled only at capture
in_valid  in  1  input array valid
in_ready  out  1  high only in IDLE
in  in  signed [IL+FL-1:0] [lane][16]  lane result array
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out  out  signed [IL+FL-1:0] [16]  output beat
out_lane  out  clog2(lane)  lane index of beat (0 in reduce mode)
out_last  out  1  final beat of the block

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; counter=0; capture register and accumulators cleared to 0.
  - Outputs: out_valid=0, out=0, out_lane=0, out_last=0, in_ready=1.
  - Reset asserted mid-operation aborts the block; no partial beat is emitted after release.
- States: IDLE, DRAIN, REDUCE, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in[][] into reg_in and latch mode into mode_q.
  - mode_q=1 -> DRAIN with cnt=0.
  - mode_q=0 -> acc=reg_in[0]; cnt=1; next state REDUCE, or EMIT if lane==1.
- DRAIN:
  - out_valid=1, out=reg_in[cnt], out_lane=cnt, out_last=(cnt==lane-1).
  - On out_valid&&out_ready: cnt++.
  - On the last handshake: go to IDLE and reset cnt to 0.
  - While out_ready=0, all outputs hold stable.
- REDUCE:
  - Each cycle, for k in 0..15: acc[k] = sat(acc[k] + reg_in[cnt][k]); then cnt++.
  - When cnt==lane-1 has been added -> EMIT.
  - Takes lane-1 cycles; out_valid=0 throughout.
- EMIT:
  - out_valid=1, out=acc, out_lane=0, out_last=1.
  - On handshake -> IDLE.
- Arithmetic:
  - Each add is computed at IL+FL+1 bits.
  - Result above 2^(IL+FL-1)-1 clamps to SAT_MAX (0x7FFFF at defaults).
  - Result below -2^(IL+FL-1) clamps to SAT_MIN (0x80000).
  - Saturation is applied per step, so the reduction is sequential saturating.
- Latency from the capture edge:
  - Drain mode: first beat valid the next cycle.
  - Reduce mode: out_valid after lane cycles (1 cycle when lane==1).
- Throughput:
  - in_ready is low outside IDLE, so at least one IDLE cycle separates blocks.
  - in_valid arriving outside IDLE is ignored (not captured).
- Output stability: out and out_lane change only on a handshake or a state change. out is driven from registered state only; no combinational path from in or out_ready to out.
- mode changes after capture have no effect on the block in flight.

Decomposition:
- Package dataflow_pkg holds:
  - fixed_t (signed [IL+FL-1:0]) typedef
  - collect_state_t enum (IDLE, DRAIN, REDUCE, EMIT)
  - SAT_MAX and SAT_MIN constants
- One sub-module: sat_add_vec, a combinational 16-wide saturating adder used by REDUCE.

Test Plan:
- Reset and idle: release reset with in_valid=0 -> out_valid=0, out=0, in_ready=1 for 10 cycles.
- Drain, lane=4, out_ready=1, in[j][k]=j*0x10000+k -> 4 beats on consecutive cycles, out_lane=0..3, out[k] of beat j = j*0x10000+k, out_last only on beat 3, in_ready back to 1 the cycle after.
- Drain with backpressure: out_ready low for 3 cycles on beat 1 -> beat 1 values, out_lane=1 and out_valid held stable; the sequence then completes unchanged.
- Reduce, lane=4: lanes = 1.0, -0.5, 0.25, 0 (0x10000, -0x8000, 0x4000, 0) -> single beat, all out[k]=0xC000, out_lane=0, out_last=1, valid 4 cycles after capture.
- Saturation, lane=4: all words 2.5 (0x28000) -> out[k]=0x7FFFF. All words -2.5 -> out[k]=0x80000 (SAT_MIN).
- Reset mid-DRAIN after beat 1: out_valid drops asynchronously. After release, a new block captured in mode 1 drains from out_lane=0 with the new data.
